// File: rtl/cla_nibble_seq_if.sv
// rtl/cla_nibble_seq_if.sv - operand/result handshake bundle for cla_nibble_seq
interface cla_nibble_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_nibble_seq.sv
// rtl/cla_nibble_seq.sv - multi-cycle adder sequencing one shared 4-bit CLA slice
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c[3:0];
    c_o  = c[4];
  end
endmodule

module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_nibble_seq_if.slave     bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] acc_shift;

  cla_4bit u_slice (
    .a_i (a_sh_q[3:0]),
    .b_i (b_sh_q[3:0]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_co)
  );

  // Each nibble result enters at the top so the LS nibble ends up at bit 0 after N steps.
  generate
    if (WIDTH == 4) begin : g_acc_single
      assign acc_shift = slice_s;
    end else begin : g_acc_multi
      assign acc_shift = {slice_s, acc_q[WIDTH-1:4]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          sa_d    = bus.a[WIDTH-1];
          sb_d    = bus.b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        acc_d   = acc_shift;
        carry_d = slice_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d     = DONE;
          sum_d       = acc_shift;
          cout_d      = slice_co;
          ovf_d       = (sa_q == sb_q) && (acc_shift[WIDTH-1] != sa_q);
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb/tb_cla_nibble_seq.sv - scoreboard bench for cla_nibble_seq (WIDTH 16 and 4)
module tb_cla_nibble_seq;
  localparam int N16 = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   accept_cyc;
  bit   rand_rdy;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  cla_nibble_seq_if #(.WIDTH(16)) bus16 ();
  cla_nibble_seq_if #(.WIDTH(4))  bus4 ();

  cla_nibble_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cla_nibble_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus16.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples just after the falling edge so bench-driven inputs have settled.
  initial begin
    exp_t e;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus16.out_valid && !prev_ov) check("latency", cyc - accept_cyc, N16);
        if (bus16.out_valid && bus16.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got sum=%h with empty scoreboard, required no result", bus16.sum);
          end else begin
            e = exp_q.pop_front();
            check("sum", bus16.sum, e.sum);
            check("cout", bus16.cout, e.cout);
            check("ovf", bus16.ovf, e.ovf);
          end
        end
      end
      prev_ov = bus16.out_valid;
    end
  end

  task automatic wait_idle16();
    int n = 0;
    while (!bus16.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus16.in_ready) check("idle_timeout", 0, 1);
  endtask

  // Called just after a falling edge; returns at the falling edge following the accept.
  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    bus16.a = a;
    bus16.b = b;
    bus16.cin = c;
    bus16.in_valid = 1'b1;
    wait_idle16();
    if (!bus16.in_ready) begin
      bus16.in_valid = 1'b0;
      return;
    end
    e.sum = es;
    e.cout = ec;
    e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    bus16.in_valid = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] es, input logic ec, input logic eo);
    int n = 0;
    bus4.a = a;
    bus4.b = b;
    bus4.cin = c;
    bus4.in_valid = 1'b1;
    while (!bus4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check("w4_not_yet_valid", bus4.out_valid, 0);
    @(negedge clk);
    check("w4_valid", bus4.out_valid, 1);
    check("w4_sum", bus4.sum, es);
    check("w4_cout", bus4.cout, ec);
    check("w4_ovf", bus4.ovf, eo);
    @(negedge clk);
    check("w4_back_idle", bus4.in_ready, 1);
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc, ro;
    int          n;
    total = 0;
    bad = 0;
    accept_cyc = 0;
    rand_rdy = 1'b0;
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.cin = 1'b0;  bus4.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", bus16.in_ready, 1);
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_sum", bus16.sum, 16'h0000);
    check("rst_cout", bus16.cout, 0);
    check("rst_ovf", bus16.ovf, 0);

    run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    run4(4'h8, 4'h8, 1'b1, 4'h1, 1'b1, 1'b1);

    @(negedge clk);
    drive16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("early_valid", bus16.out_valid, 0);
    @(negedge clk);
    check("valid_at_n", bus16.out_valid, 1);
    check("busy_in_done", bus16.in_ready, 0);
    @(negedge clk);
    check("ready_after_hs", bus16.in_ready, 1);
    check("valid_after_hs", bus16.out_valid, 0);

    drive16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    drive16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    drive16(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_idle16();

    bus16.out_ready = 1'b0;
    drive16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus16.in_valid = ~bus16.in_valid;
      bus16.a = 16'($urandom);
      bus16.b = 16'($urandom);
      @(negedge clk);
      check("bp_valid", bus16.out_valid, 1);
      check("bp_in_ready", bus16.in_ready, 0);
      check("bp_sum", bus16.sum, 16'h5555);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", bus16.out_valid, 0);
    check("bp_release_idle", bus16.in_ready, 1);
    @(negedge clk);
    check("bp_queue_empty", exp_q.size(), 0);

    // Abort an add mid-RUN: no result may ever surface from it.
    bus16.a = 16'hABCD;
    bus16.b = 16'h1111;
    bus16.cin = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_valid", bus16.out_valid, 0);
    check("mid_rst_sum", bus16.sum, 16'h0000);
    check("mid_rst_in_ready", bus16.in_ready, 1);
    repeat (6) @(negedge clk);
    check("mid_rst_no_pulse", bus16.out_valid, 0);
    drive16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_idle16();

    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      ro = (ra[15] == rb[15]) && (full[15] != ra[15]);
      drive16(ra, rb, rc, full[15:0], full[16], ro);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rand_rdy = 1'b0;
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
